// File: rtl/if_id_skid_register.sv
// IF/ID pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Carries PC+4 and the instruction word from fetch to decode. in_ready is a
// flop so the decode stall path never reaches fetch combinationally. State
// updates on the falling clock edge to match the rest of the pipeline.
module if_id_skid_register #(
  parameter int unsigned             NBits     = 32,
  parameter logic [NBits-1:0]        NOP_INSTR = '0,
  parameter int unsigned             CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBits-1:0] in_PC_4,
  input  logic [NBits-1:0] in_Instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBits-1:0] out_PC_4,
  output logic [NBits-1:0] out_Instruction,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic             in_ready_q, in_ready_d;
  logic [NBits-1:0] main_pc_q,  main_pc_d;
  logic [NBits-1:0] main_ins_q, main_ins_d;
  logic [NBits-1:0] skid_pc_q,  skid_pc_d;
  logic [NBits-1:0] skid_ins_q, skid_ins_d;
  logic [CNT_W-1:0] stall_q,    stall_d;

  logic in_xfer;
  logic out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  // Occupancy next-state and entry movement; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    main_pc_d  = main_pc_q;
    main_ins_d = main_ins_q;
    skid_pc_d  = skid_pc_q;
    skid_ins_d = skid_ins_q;
    if (flush) begin
      state_d    = EMPTY;
      main_pc_d  = '0;
      main_ins_d = '0;
      skid_pc_d  = '0;
      skid_ins_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d    = ONE;
            main_pc_d  = in_PC_4;
            main_ins_d = in_Instruction;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_pc_d  = in_PC_4;
            main_ins_d = in_Instruction;
          end else if (in_xfer) begin
            state_d    = TWO;
            skid_pc_d  = in_PC_4;
            skid_ins_d = in_Instruction;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d    = ONE;
            main_pc_d  = skid_pc_q;
            main_ins_d = skid_ins_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  // Saturating count of edges where decode holds off a valid word.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // State registers, falling-edge clocked with asynchronous reset.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_pc_q  <= '0;
      main_ins_q <= '0;
      skid_pc_q  <= '0;
      skid_ins_q <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_pc_q  <= main_pc_d;
      main_ins_q <= main_ins_d;
      skid_pc_q  <= skid_pc_d;
      skid_ins_q <= skid_ins_d;
      stall_q    <= stall_d;
    end
  end

  // Main entry stays stale after the last word leaves, so mask it when empty.
  always_comb begin
    out_PC_4        = '0;
    out_Instruction = NOP_INSTR;
    if (out_valid) begin
      out_PC_4        = main_pc_q;
      out_Instruction = main_ins_q;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_if_id_skid_register.sv
// Directed and randomised checks for if_id_skid_register.
module tb_if_id_skid_register;

  localparam int unsigned NB    = 32;
  localparam int unsigned CW    = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_PC_4;
  logic [NB-1:0] in_Instruction;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_PC_4;
  logic [NB-1:0] out_Instruction;
  logic [CW-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  if_id_skid_register #(
    .NBits    (NB),
    .NOP_INSTR(NOP),
    .CNT_W    (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_PC_4        (in_PC_4),
    .in_Instruction (in_Instruction),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_PC_4       (out_PC_4),
    .out_Instruction(out_Instruction),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the active (falling) edge and settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    in_valid       = v;
    in_PC_4        = pc;
    in_Instruction = ins;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  logic [63:0] q[$];
  int unsigned m_stall;
  logic        m_in_x, m_out_x;

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(1'b0, '0, '0);
    #3;
    reset = 1'b0;

    // Reset from TWO, mid-cycle, no clock edge needed
    out_ready = 1'b0;
    offer(1'b1, 32'h4, 32'h0000_0A0A);
    step();
    offer(1'b1, 32'h8, 32'h0000_0B0B);
    step();
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("pre_rst_ready", {63'd0, in_ready}, 64'd0);
    chk("pre_rst_stall", {60'd0, stall_cycles}, 64'd1);
    offer(1'b0, '0, '0);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_ins", {32'd0, out_Instruction}, {32'd0, NOP});
    chk("rst_pc", {32'd0, out_PC_4}, 64'd0);
    chk("rst_stall", {60'd0, stall_cycles}, 64'd0);
    #1;
    reset = 1'b0;

    // Streaming
    out_ready = 1'b1;
    offer(1'b1, 32'd4, 32'h11);
    step();
    chk("s1_ins", {32'd0, out_Instruction}, 64'h11);
    chk("s1_pc", {32'd0, out_PC_4}, 64'd4);
    chk("s1_ready", {63'd0, in_ready}, 64'd1);
    offer(1'b1, 32'd8, 32'h22);
    step();
    chk("s2_ins", {32'd0, out_Instruction}, 64'h22);
    chk("s2_pc", {32'd0, out_PC_4}, 64'd8);
    chk("s2_ready", {63'd0, in_ready}, 64'd1);
    offer(1'b1, 32'd12, 32'h33);
    step();
    chk("s3_ins", {32'd0, out_Instruction}, 64'h33);
    chk("s3_pc", {32'd0, out_PC_4}, 64'd12);
    chk("s3_ready", {63'd0, in_ready}, 64'd1);
    offer(1'b0, 32'hDEAD, 32'hBEEF);
    step();
    chk("s4_valid", {63'd0, out_valid}, 64'd0);
    chk("s4_ins", {32'd0, out_Instruction}, {32'd0, NOP});
    chk("s4_pc", {32'd0, out_PC_4}, 64'd0);
    chk("s4_stall", {60'd0, stall_cycles}, 64'd0);

    // Skid fill and drain
    out_ready = 1'b0;
    offer(1'b1, 32'h100, 32'hA0);
    step();
    chk("k1_ins", {32'd0, out_Instruction}, 64'hA0);
    chk("k1_ready", {63'd0, in_ready}, 64'd1);
    offer(1'b1, 32'h104, 32'hA1);
    step();
    chk("k2_ins", {32'd0, out_Instruction}, 64'hA0);
    chk("k2_ready", {63'd0, in_ready}, 64'd0);
    chk("k2_stall", {60'd0, stall_cycles}, 64'd1);
    offer(1'b1, 32'h108, 32'hA2);
    step();
    chk("k3_ins", {32'd0, out_Instruction}, 64'hA0);
    chk("k3_pc", {32'd0, out_PC_4}, 64'h100);
    chk("k3_ready", {63'd0, in_ready}, 64'd0);
    chk("k3_stall", {60'd0, stall_cycles}, 64'd2);
    out_ready = 1'b1;
    step();
    chk("k4_ins", {32'd0, out_Instruction}, 64'hA1);
    chk("k4_pc", {32'd0, out_PC_4}, 64'h104);
    chk("k4_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("k5_ins", {32'd0, out_Instruction}, 64'hA2);
    chk("k5_pc", {32'd0, out_PC_4}, 64'h108);
    offer(1'b0, '0, '0);
    step();
    chk("k6_valid", {63'd0, out_valid}, 64'd0);
    chk("k6_stall", {60'd0, stall_cycles}, 64'd2);

    // Flush from TWO while fetch offers 0xB2
    out_ready = 1'b0;
    offer(1'b1, 32'h200, 32'hB0);
    step();
    offer(1'b1, 32'h204, 32'hB1);
    step();
    offer(1'b1, 32'h208, 32'hB2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("f1_valid", {63'd0, out_valid}, 64'd0);
    chk("f1_ins", {32'd0, out_Instruction}, {32'd0, NOP});
    chk("f1_ready", {63'd0, in_ready}, 64'd1);
    chk("f1_stall", {60'd0, stall_cycles}, 64'd4);
    out_ready = 1'b1;
    offer(1'b1, 32'h300, 32'hC0);
    step();
    chk("f2_ins", {32'd0, out_Instruction}, 64'hC0);
    chk("f2_pc", {32'd0, out_PC_4}, 64'h300);
    offer(1'b0, '0, '0);
    step();
    chk("f3_valid", {63'd0, out_valid}, 64'd0);

    // Flush from ONE with a real handshake at the flush edge
    out_ready = 1'b0;
    offer(1'b1, 32'h400, 32'hD0);
    step();
    offer(1'b1, 32'h404, 32'hD1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("f4_valid", {63'd0, out_valid}, 64'd0);
    chk("f4_ready", {63'd0, in_ready}, 64'd1);
    chk("f4_stall", {60'd0, stall_cycles}, 64'd5);
    out_ready = 1'b1;
    offer(1'b1, 32'h500, 32'hE0);
    step();
    chk("f5_ins", {32'd0, out_Instruction}, 64'hE0);
    offer(1'b0, '0, '0);
    step();
    chk("f6_valid", {63'd0, out_valid}, 64'd0);

    // Saturation of the 4-bit counter
    do_reset();
    out_ready = 1'b0;
    offer(1'b1, 32'h600, 32'hF0);
    step();
    offer(1'b0, '0, '0);
    for (int i = 0; i < 10; i++) step();
    chk("sat10", {60'd0, stall_cycles}, 64'd10);
    for (int i = 0; i < 10; i++) step();
    chk("sat20", {60'd0, stall_cycles}, 64'd15);
    for (int i = 0; i < 5; i++) step();
    chk("sat25", {60'd0, stall_cycles}, 64'd15);
    chk("sat_ins", {32'd0, out_Instruction}, 64'hF0);

    // Random traffic against a reference FIFO
    do_reset();
    q.delete();
    m_stall = 0;
    for (int i = 0; i < 400; i++) begin
      offer(1'($urandom_range(0, 1)), $urandom, $urandom);
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 99) < 5);
      m_in_x    = in_valid && (q.size() < 2);
      m_out_x   = (q.size() > 0) && out_ready;
      if ((q.size() > 0) && !out_ready && (m_stall < 15)) m_stall++;
      step();
      if (flush) begin
        q.delete();
      end else begin
        if (m_out_x) void'(q.pop_front());
        if (m_in_x) q.push_back({in_PC_4, in_Instruction});
      end
      chk("r_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0)});
      chk("r_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
      if (q.size() > 0)
        chk("r_word", {out_PC_4, out_Instruction}, q[0]);
      else
        chk("r_word", {out_PC_4, out_Instruction}, {32'd0, NOP});
      chk("r_stall", {60'd0, stall_cycles}, 64'(m_stall));
    end
    flush = 1'b0;
    offer(1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
